// File: rtl/tb_mem_arb.sv
// Two-master arbiter sharing one synchronous memory between a JTAG memory-space
// slot, which always wins, and a req/gnt user master that stalls while JTAG is active.
module tb_mem_arb #(
  parameter int MEM_SEL    = 0,
  parameter int AW         = 12,
  parameter int RD_LATENCY = 1
) (
  input  logic          sysclk,
  input  logic          sys_rstn,
  input  logic [7:0]    jt_ce,
  input  logic          jt_we,
  input  logic [29:0]   jt_addr,
  input  logic [31:0]   jt_wd,
  input  logic [3:0]    jt_bytesel,
  output logic [31:0]   jt_rd,
  input  logic          usr_req,
  input  logic          usr_we,
  input  logic [AW-1:0] usr_addr,
  input  logic [31:0]   usr_wd,
  input  logic [3:0]    usr_bytesel,
  output logic          usr_gnt,
  output logic          usr_rvalid,
  output logic [31:0]   usr_rd,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd,
  output logic [15:0]   usr_stall_cnt
);

  localparam logic [31:0] OOB_WORD = 32'hBADADD00;
  localparam int          NSTG     = RD_LATENCY + 1;

  typedef struct packed {
    logic valid;
    logic jt;
    logic rd;
    logic oob;
  } tag_t;

  logic          jt_hit_s;
  logic          jt_oob_s;
  logic          nxt_en_s;
  logic [3:0]    nxt_we_s;
  logic [AW-1:0] nxt_addr_s;
  logic [31:0]   nxt_wd_s;
  tag_t          nxt_tag_s;
  tag_t          tag_r [NSTG];
  tag_t          done_s;
  logic          unused_ce_s;

  assign jt_hit_s    = jt_ce[MEM_SEL];
  assign usr_gnt     = usr_req && !jt_hit_s;
  assign done_s      = tag_r[RD_LATENCY];
  assign unused_ce_s = ^jt_ce;

  // With a full 30-bit memory there are no upper address bits to range-check.
  generate
    if (AW < 30) begin : g_oob
      assign jt_oob_s = |jt_addr[29:AW];
    end else begin : g_no_oob
      assign jt_oob_s = 1'b0;
    end
  endgenerate

  // Pick this cycle's single winner and form the next memory command and tag.
  always_comb begin
    nxt_en_s   = 1'b0;
    nxt_we_s   = 4'b0000;
    nxt_addr_s = mem_addr;
    nxt_wd_s   = mem_wd;
    nxt_tag_s  = '{valid: 1'b0, jt: 1'b0, rd: 1'b0, oob: 1'b0};
    if (jt_hit_s) begin
      nxt_addr_s = jt_addr[AW-1:0];
      nxt_wd_s   = jt_wd;
      nxt_tag_s  = '{valid: 1'b1, jt: 1'b1, rd: !jt_we, oob: jt_oob_s};
      if (jt_we) begin
        if (!jt_oob_s && (jt_bytesel != 4'b0000)) begin
          nxt_en_s = 1'b1;
          nxt_we_s = jt_bytesel;
        end else begin
          nxt_en_s = 1'b0;
          nxt_we_s = 4'b0000;
        end
      end else begin
        nxt_en_s = !jt_oob_s;
      end
    end else if (usr_req) begin
      nxt_en_s   = 1'b1;
      nxt_we_s   = usr_we ? usr_bytesel : 4'b0000;
      nxt_addr_s = usr_addr;
      nxt_wd_s   = usr_wd;
      nxt_tag_s  = '{valid: 1'b1, jt: 1'b0, rd: !usr_we, oob: 1'b0};
    end else begin
      nxt_en_s = 1'b0;
    end
  end

  // Registered memory command.
  always_ff @(posedge sysclk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      mem_en   <= 1'b0;
      mem_we   <= 4'b0000;
      mem_addr <= {AW{1'b0}};
      mem_wd   <= 32'h0000_0000;
    end else begin
      mem_en   <= nxt_en_s;
      mem_we   <= nxt_we_s;
      mem_addr <= nxt_addr_s;
      mem_wd   <= nxt_wd_s;
    end
  end

  // Owner tags travel alongside the memory latency so completions keep issue order.
  always_ff @(posedge sysclk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      for (int k = 0; k < NSTG; k++) begin
        tag_r[k] <= '{valid: 1'b0, jt: 1'b0, rd: 1'b0, oob: 1'b0};
      end
    end else begin
      tag_r[0] <= nxt_tag_s;
      for (int k = 1; k < NSTG; k++) begin
        tag_r[k] <= tag_r[k-1];
      end
    end
  end

  // Read return steering; jt_rd only moves on a JTAG read completion.
  always_ff @(posedge sysclk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      jt_rd      <= 32'h0000_0000;
      usr_rd     <= 32'h0000_0000;
      usr_rvalid <= 1'b0;
    end else begin
      usr_rvalid <= 1'b0;
      if (done_s.valid && done_s.rd) begin
        if (done_s.jt) begin
          jt_rd <= done_s.oob ? OOB_WORD : mem_rd;
        end else begin
          usr_rd     <= mem_rd;
          usr_rvalid <= 1'b1;
        end
      end
    end
  end

  // Saturating count of user cycles lost to JTAG.
  always_ff @(posedge sysclk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      usr_stall_cnt <= 16'h0000;
    end else if (usr_req && jt_hit_s && (usr_stall_cnt != 16'hFFFF)) begin
      usr_stall_cnt <= usr_stall_cnt + 16'h0001;
    end
  end

endmodule
